// File: rtl/block_lock_arbiter_if.sv
// Bundle of requester-side and block-manager-side signals for the lock arbiter.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface block_lock_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int BLOCK_WIDTH = 9
);
  // requester side
  logic [N_REQ-1:0]             req_strobe_i;
  logic [N_REQ-1:0]             req_lock_i;
  logic [N_REQ-1:0]             req_unlock_i;
  logic [N_REQ*BLOCK_WIDTH-1:0] req_address_i;
  logic [N_REQ-1:0]             req_ack_o;
  // block manager side
  logic [BLOCK_WIDTH-1:0]       lock_address_o;
  logic                         lock_o;
  logic                         unlock_o;
  logic                         lock_strobe_o;
  logic                         lock_ack_i;
  // status and error reporting
  logic                         busy_o;
  logic                         err_clear_i;
  logic                         timeout_error_o;
  logic                         spurious_ack_o;
  logic [2:0]                   last_error_req_o;

  modport slave (
    input  req_strobe_i, req_lock_i, req_unlock_i, req_address_i,
    input  lock_ack_i, err_clear_i,
    output req_ack_o, lock_address_o, lock_o, unlock_o, lock_strobe_o,
    output busy_o, timeout_error_o, spurious_ack_o, last_error_req_o
  );

  modport master (
    output req_strobe_i, req_lock_i, req_unlock_i, req_address_i,
    output lock_ack_i, err_clear_i,
    input  req_ack_o, lock_address_o, lock_o, unlock_o, lock_strobe_o,
    input  busy_o, timeout_error_o, spurious_ack_o, last_error_req_o
  );
endinterface

// File: rtl/block_lock_arbiter.sv
// Round-robin arbiter in front of the block manager's single lock/unlock port.
// One transaction at a time: IDLE picks a requester, ISSUE strobes the block
// manager, WAIT collects the acknowledge (or gives up after ACK_TIMEOUT cycles),
// DONE returns a one-cycle ack to the winner. Sticky flags report protocol faults.
module block_lock_arbiter #(
  parameter int N_REQ       = 4,
  parameter int BLOCK_WIDTH = 9,
  parameter int ACK_TIMEOUT = 15
) (
  input logic                clk,
  input logic                reset,
  block_lock_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       grant_reg, grant_next;
  logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
  logic [BLOCK_WIDTH-1:0] addr_reg, addr_next;
  logic                   lock_reg, lock_next;
  logic                   unlock_reg, unlock_next;
  logic [7:0]             count_reg, count_next;
  logic                   timeout_err_reg, timeout_err_next;
  logic                   spurious_reg, spurious_next;
  logic [2:0]             last_err_reg, last_err_next;

  // cand[gi] is the requester examined at priority position gi, starting one
  // past the previous winner and wrapping; cand_hit marks which are requesting.
  logic [IDX_W-1:0]       cand [N_REQ];
  logic [N_REQ-1:0]       cand_hit;
  logic [BLOCK_WIDTH-1:0] addr_arr [N_REQ];
  logic [N_REQ-1:0]       ack_vec;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign cand[gi]     = IDX_W'((int'(last_grant_reg) + gi + 1) % N_REQ);
      assign cand_hit[gi] = bus.req_strobe_i[cand[gi]];
      assign addr_arr[gi] = bus.req_address_i[gi*BLOCK_WIDTH +: BLOCK_WIDTH];
      assign ack_vec[gi]  = (state_reg == ST_DONE) && (grant_reg == IDX_W'(gi));
    end
  endgenerate

  // Pick the asserted candidate closest after the previous winner.
  always_comb begin
    sel_valid = |cand_hit;
    sel_idx   = cand[0];
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) sel_idx = cand[i];
    end
  end

  // Next-state logic: transaction sequencing, watchdog and sticky error flags.
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_grant_next  = last_grant_reg;
    addr_next        = addr_reg;
    lock_next        = lock_reg;
    unlock_next      = unlock_reg;
    count_next       = count_reg;
    timeout_err_next = timeout_err_reg;
    spurious_next    = spurious_reg;
    last_err_next    = last_err_reg;

    // Clear first so that a fault in the same cycle overrides it.
    if (bus.err_clear_i) begin
      timeout_err_next = 1'b0;
      spurious_next    = 1'b0;
    end
    if (bus.lock_ack_i && (state_reg != ST_WAIT)) begin
      spurious_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_next      = sel_idx;
          last_grant_next = sel_idx;
          addr_next       = addr_arr[sel_idx];
          lock_next       = bus.req_lock_i[sel_idx];
          unlock_next     = bus.req_unlock_i[sel_idx];
          state_next      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        count_next = 8'd0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack in the final watchdog cycle still counts as a normal ack.
        if (bus.lock_ack_i) begin
          state_next = ST_DONE;
        end else begin
          count_next = count_reg + 8'd1;
          if ((count_reg + 8'd1) == 8'(ACK_TIMEOUT)) begin
            timeout_err_next = 1'b1;
            last_err_next    = 3'(grant_reg);
            state_next       = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= IDX_W'(N_REQ - 1);
      addr_reg        <= '0;
      lock_reg        <= 1'b0;
      unlock_reg      <= 1'b0;
      count_reg       <= 8'd0;
      timeout_err_reg <= 1'b0;
      spurious_reg    <= 1'b0;
      last_err_reg    <= 3'd0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_grant_reg  <= last_grant_next;
      addr_reg        <= addr_next;
      lock_reg        <= lock_next;
      unlock_reg      <= unlock_next;
      count_reg       <= count_next;
      timeout_err_reg <= timeout_err_next;
      spurious_reg    <= spurious_next;
      last_err_reg    <= last_err_next;
    end
  end

  assign bus.req_ack_o        = ack_vec;
  assign bus.lock_strobe_o    = (state_reg == ST_ISSUE);
  assign bus.busy_o           = (state_reg != ST_IDLE);
  assign bus.lock_address_o   = addr_reg;
  assign bus.lock_o           = lock_reg;
  assign bus.unlock_o         = unlock_reg;
  assign bus.timeout_error_o  = timeout_err_reg;
  assign bus.spurious_ack_o   = spurious_reg;
  assign bus.last_error_req_o = last_err_reg;

endmodule

// File: tb/tb_block_lock_arbiter.sv
// Self-checking bench for block_lock_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_block_lock_arbiter;

  localparam int N_REQ = 4;
  localparam int BW    = 9;
  localparam int T     = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_lock_arbiter_if #(.N_REQ(N_REQ), .BLOCK_WIDTH(BW)) bus ();

  block_lock_arbiter #(.N_REQ(N_REQ), .BLOCK_WIDTH(BW), .ACK_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int txn_count = 0;

  // reference model state
  int   m_last_grant;
  bit   m_timeout;
  bit   m_spurious;
  int   m_last_err;
  logic [N_REQ-1:0] reraise_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [N_REQ-1:0] s, input int last);
    for (int off = 1; off <= N_REQ; off++) begin
      int c;
      c = (last + off) % N_REQ;
      if (s[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last_grant = N_REQ - 1;
    m_timeout    = 1'b0;
    m_spurious   = 1'b0;
    m_last_err   = 0;
  endtask

  task automatic set_req(input int r, input bit lk, input bit ul, input logic [BW-1:0] a);
    bus.req_strobe_i[r]          = 1'b1;
    bus.req_lock_i[r]            = lk;
    bus.req_unlock_i[r]          = ul;
    bus.req_address_i[r*BW +: BW] = a;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ack"},   bus.req_ack_o, 0);
    check({tag, "_strobe"},    bus.lock_strobe_o, 0);
    check({tag, "_lock"},      bus.lock_o, 0);
    check({tag, "_unlock"},    bus.unlock_o, 0);
    check({tag, "_addr"},      bus.lock_address_o, 0);
    check({tag, "_busy"},      bus.busy_o, 0);
    check({tag, "_timeout"},   bus.timeout_error_o, 0);
    check({tag, "_spurious"},  bus.spurious_ack_o, 0);
    check({tag, "_last_err"},  bus.last_error_req_o, 0);
  endtask

  // One IDLE cycle with no requests pending; optional stray ack and error clear.
  task automatic idle_cycle(input bit ack, input bit clr);
    bus.lock_ack_i  = ack;
    bus.err_clear_i = clr;
    tick();
    bus.lock_ack_i  = 1'b0;
    bus.err_clear_i = 1'b0;
    if (clr) begin
      m_timeout  = 1'b0;
      m_spurious = 1'b0;
    end
    if (ack) m_spurious = 1'b1;
    check("idle_spurious", bus.spurious_ack_o, m_spurious);
    check("idle_timeout",  bus.timeout_error_o, m_timeout);
    check("idle_no_ack",   bus.req_ack_o, 0);
    check("idle_no_strobe", bus.lock_strobe_o, 0);
    check("idle_busy",     bus.busy_o, 0);
  endtask

  // Full transaction starting from IDLE with requests already driven.
  // ack_delay = WAIT cycle (0-based) carrying lock_ack_i; >= T means withheld.
  task automatic do_txn(input int ack_delay, output int obs_idx);
    int w;
    logic [BW-1:0] ea;
    bit el, eu, timed_out;
    int waits;
    w = model_pick(bus.req_strobe_i, m_last_grant);
    if (w < 0) $fatal(1, "FAIL txn_setup: no request pending");
    ea = bus.req_address_i[w*BW +: BW];
    el = bus.req_lock_i[w];
    eu = bus.req_unlock_i[w];
    m_last_grant = w;

    tick();  // ISSUE
    bus.req_strobe_i = bus.req_strobe_i | reraise_mask;
    reraise_mask = '0;
    check("issue_strobe", bus.lock_strobe_o, 1);
    check("issue_addr",   bus.lock_address_o, ea);
    check("issue_lock",   bus.lock_o, el);
    check("issue_unlock", bus.unlock_o, eu);
    check("issue_busy",   bus.busy_o, 1);
    check("issue_no_ack", bus.req_ack_o, 0);

    tick();  // first WAIT cycle
    timed_out = 1'b1;
    waits = 0;
    for (int i = 0; i < T; i++) begin
      check("wait_no_strobe", bus.lock_strobe_o, 0);
      check("wait_no_ack",    bus.req_ack_o, 0);
      check("wait_busy",      bus.busy_o, 1);
      bus.lock_ack_i = (i == ack_delay);
      tick();
      bus.lock_ack_i = 1'b0;
      waits++;
      if (i == ack_delay) begin
        timed_out = 1'b0;
        break;
      end
    end

    // DONE
    if (timed_out) begin
      m_timeout  = 1'b1;
      m_last_err = w;
    end
    obs_idx = -1;
    for (int r = 0; r < N_REQ; r++) if (bus.req_ack_o[r]) obs_idx = r;
    check("done_ack",      bus.req_ack_o, 32'(1) << w);
    check("done_strobe",   bus.lock_strobe_o, 0);
    check("done_addr",     bus.lock_address_o, ea);
    check("done_lock",     bus.lock_o, el);
    check("done_unlock",   bus.unlock_o, eu);
    check("done_timeout",  bus.timeout_error_o, m_timeout);
    check("done_spurious", bus.spurious_ack_o, m_spurious);
    check("done_last_err", bus.last_error_req_o, m_last_err);
    $display("txn %0d: req %0d addr 0x%03h lock %0b unlock %0b wait_cycles %0d timeout %0b",
             txn_count, w, ea, el, eu, waits, timed_out);
    txn_count++;

    tick();  // back in IDLE; requester drops its strobe after the ack edge
    bus.req_strobe_i[w] = 1'b0;
    check("post_busy",   bus.busy_o, 0);
    check("post_no_ack", bus.req_ack_o, 0);
  endtask

  int obs;
  int rr_expect [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1;
    bus.req_strobe_i  = '0;
    bus.req_lock_i    = '0;
    bus.req_unlock_i  = '0;
    bus.req_address_i = '0;
    bus.lock_ack_i    = 1'b0;
    bus.err_clear_i   = 1'b0;
    reraise_mask      = '0;
    model_reset();

    // reset state
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // single request, ack one cycle after the strobe
    set_req(2, 1'b1, 1'b0, 9'h1A5);
    do_txn(0, obs);
    check("single_grant", obs, 2);

    // round robin from a fresh reset, all requesters held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    for (int r = 0; r < N_REQ; r++) set_req(r, r[0], r[1], BW'(9'h040 + r));
    for (int i = 0; i < 6; i++) begin
      do_txn(0, obs);
      check("rr_order", obs, rr_expect[i]);
      reraise_mask = '0;
      reraise_mask[obs] = 1'b1;
    end
    bus.req_strobe_i = '0;
    reraise_mask = '0;

    // simultaneous lock and unlock
    set_req(1, 1'b1, 1'b1, 9'h003);
    do_txn(1, obs);
    check("both_grant", obs, 1);

    // timeout, then clear
    set_req(3, 1'b0, 1'b1, 9'h0F0);
    do_txn(T + 5, obs);
    check("timeout_grant", obs, 3);
    idle_cycle(1'b0, 1'b1);

    // spurious ack, set wins against clear, then clear
    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b0, 1'b1);

    // ack in the final watchdog cycle is a normal ack
    set_req(0, 1'b1, 1'b0, 9'h1FF);
    do_txn(T - 1, obs);
    check("late_ack_grant", obs, 0);

    // reset one cycle after the strobe
    set_req(1, 1'b1, 1'b0, 9'h0AA);
    tick();
    check("rst_issue_strobe", bus.lock_strobe_o, 1);
    tick();
    reset = 1'b1;
    tick();
    bus.req_strobe_i = '0;
    model_reset();
    check_reset_outputs("rst_wait");
    reset = 1'b0;
    tick();
    check("rst_release_no_ack", bus.req_ack_o, 0);
    set_req(0, 1'b0, 1'b0, 9'h011);
    set_req(1, 1'b1, 1'b0, 9'h0AA);
    set_req(2, 1'b0, 1'b1, 9'h122);
    do_txn(2, obs);
    check("rst_next_grant", obs, 0);
    bus.req_strobe_i = '0;

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int d;
      int sel;
      if (bus.req_strobe_i == '0) begin
        logic [N_REQ-1:0] m;
        idle_cycle(($urandom % 4) == 0, ($urandom % 4) == 0);
        m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
        for (int r = 0; r < N_REQ; r++)
          if (m[r]) set_req(r, 1'($urandom), 1'($urandom), BW'($urandom));
      end else if (($urandom % 3) == 0) begin
        int r;
        r = $urandom_range(0, N_REQ - 1);
        if (!bus.req_strobe_i[r]) set_req(r, 1'($urandom), 1'($urandom), BW'($urandom));
      end
      sel = $urandom % 8;
      if (sel == 0)      d = T + 3;
      else if (sel == 1) d = T - 1;
      else               d = $urandom_range(0, 3);
      do_txn(d, obs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
